// File: rtl/mem_seq_pkg.sv
// Shared constants for the byte-serial memory read sequencer: state encoding,
// default timeout and beat geometry.
package mem_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE = 3'd0;
   localparam state_t LOAD = 3'd1;
   localparam state_t READ = 3'd2;
   localparam state_t CAPT = 3'd3;
   localparam state_t INC  = 3'd4;
   localparam state_t DONE = 3'd5;
   localparam state_t ERR  = 3'd6;

   localparam int unsigned TIMEOUT_DEF = 16;
   localparam int unsigned BEATS       = 4;
   localparam int unsigned BEAT_W      = $clog2(BEATS);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

endpackage

// File: rtl/mem_read_sequencer_if.sv
// Handshake and datapath-control bundle between the read sequencer (master)
// and the bus master / memory / byte datapath around it (slave).
interface mem_read_sequencer_if;

   logic                            req;
   logic                            mem_ack;
   logic                            ldaddr;
   logic                            rst2;
   logic                            ldden;
   logic                            incc2;
   logic                            mem_rd;
   logic                            busy;
   logic                            done;
   logic                            err;
   logic [mem_seq_pkg::BEAT_W-1:0]  beat;

   modport master (
      input  req, mem_ack,
      output ldaddr, rst2, ldden, incc2, mem_rd, busy, done, err, beat
   );

   modport slave (
      output req, mem_ack,
      input  ldaddr, rst2, ldden, incc2, mem_rd, busy, done, err, beat
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge; expired_o flags the
// last permitted wait cycle.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] count_q;
   logic [TO_W-1:0] count_d;

   always_comb begin
      // NOTE: default assignment first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: non-blocking assignments for all registered state.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_read_sequencer.sv
// Moore control FSM for the byte-serial read datapath: loads the address,
// fetches BEATS bytes and reports done, or err on an acknowledge timeout.
module mem_read_sequencer
   import mem_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned TO_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_read_sequencer_if.master bus
);

   state_t              state_q;
   state_t              state_d;
   logic [BEAT_W-1:0]   beat_q;
   logic [BEAT_W-1:0]   beat_d;
   logic                expired;
   logic                timer_clear;
   logic                timer_enable;

   // Wait counter restarts on each new transfer and whenever READ is left.
   assign timer_enable = (state_q == READ);
   assign timer_clear  = (state_q == LOAD) ||
                         ((state_q == READ) && (bus.mem_ack || expired));

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (timer_clear),
      .enable_i  (timer_enable),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (bus.req) state_d = LOAD;
         end
         LOAD: begin
            beat_d  = '0;
            state_d = READ;
         end
         READ: begin
            if (bus.mem_ack) begin
               state_d = CAPT;
            end else if (expired) begin
               state_d = ERR;
            end
         end
         CAPT: begin
            state_d = INC;
         end
         INC: begin
            if (beat_q == LAST_BEAT) begin
               state_d = DONE;
            end else begin
               beat_d  = beat_q + 1'b1;
               state_d = READ;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // rst2 also follows rst directly so the datapath counter clears during reset.
   assign bus.ldaddr = (state_q == LOAD);
   assign bus.rst2   = rst || (state_q == LOAD) || (state_q == ERR);
   assign bus.ldden  = (state_q == CAPT);
   assign bus.incc2  = (state_q == INC);
   assign bus.mem_rd = (state_q == READ);
   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.err    = (state_q == ERR);
   assign bus.beat   = beat_q;

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Directed bench for mem_read_sequencer: cycle table for reset and one
// transfer, plus sequences for waits, timeout, back-to-back and mid-reset.
module tb_mem_read_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_read_sequencer_if bus ();

   mem_read_sequencer #(
      .TIMEOUT (16),
      .TO_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte datapath model driven by the strobes: counter, four byte registers.
   logic [7:0]  mem_bytes [4];
   logic [1:0]  cnt_m;
   logic [31:0] word_m;
   int          ldden_tot, incc2_tot, done_tot, err_tot, overlap_cnt, beat_mis;

   initial begin
      cnt_m = '0; word_m = '0;
      ldden_tot = 0; incc2_tot = 0; done_tot = 0; err_tot = 0;
      overlap_cnt = 0; beat_mis = 0;
   end

   always @(posedge clk) begin
      if (bus.rst2) cnt_m <= '0;
      else if (bus.incc2) cnt_m <= cnt_m + 2'd1;
      if (bus.ldden) begin
         word_m[cnt_m*8 +: 8] <= mem_bytes[cnt_m];
         ldden_tot <= ldden_tot + 1;
         if (bus.beat != cnt_m) beat_mis <= beat_mis + 1;
      end
      if (bus.incc2) incc2_tot <= incc2_tot + 1;
      if (bus.ldden && bus.incc2) overlap_cnt <= overlap_cnt + 1;
      if (bus.done) done_tot <= done_tot + 1;
      if (bus.err) err_tot <= err_tot + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] outs();
      return {bus.ldaddr, bus.rst2, bus.ldden, bus.incc2, bus.mem_rd,
              bus.busy, bus.done, bus.err, bus.beat};
   endfunction

   // Starts a transfer from IDLE and runs until done or err. wait_n < 0 means
   // mem_ack is never given. Returns with the DUT still in the DONE/ERR cycle.
   task automatic run_xfer(input int wait_n, output int done_at, output int err_at,
                           output int rd_cycles, output int ldden_n);
      int rd_run;
      bit stop;
      done_at = 0; err_at = 0; rd_cycles = 0; ldden_n = 0; rd_run = 0; stop = 0;
      bus.req = 1'b1;
      bus.mem_ack = 1'b0;
      step();
      bus.req = 1'b0;
      for (int c = 1; c <= 200 && !stop; c++) begin
         if (bus.done) begin
            done_at = c; stop = 1;
         end else if (bus.err) begin
            err_at = c; stop = 1;
         end else begin
            if (bus.ldden) ldden_n++;
            if (bus.mem_rd) begin
               rd_cycles++;
               rd_run++;
               bus.mem_ack = (wait_n >= 0) && (rd_run == wait_n + 1);
            end else begin
               rd_run = 0;
               bus.mem_ack = 1'b0;
            end
            step();
         end
      end
      bus.mem_ack = 1'b0;
   endtask

   typedef struct {
      logic       rst;
      logic       req;
      logic       ack;
      logic [9:0] exp;   // {ldaddr,rst2,ldden,incc2,mem_rd,busy,done,err,beat[1:0]}
   } vec_t;

   vec_t vecs [19];

   initial begin : main
      int done_at, err_at, rd_cycles, ldden_n, idle_between, ndone;
      int d_at [3];
      int done0, err0;
      bit found;

      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.req = 1'b0;
      bus.mem_ack = 1'b0;
      mem_bytes[0] = 8'h11; mem_bytes[1] = 8'h22;
      mem_bytes[2] = 8'h33; mem_bytes[3] = 8'h44;

      // Reset for 3 cycles, release, then one transfer with mem_ack held high.
      for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 10'b0100000000};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 10'b0000000000};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 10'b1100010000};
      for (int b = 0; b < 4; b++) begin
         vecs[5 + 3*b] = '{1'b0, 1'b0, 1'b1, 10'b0000110000 | 10'(b)};
         vecs[6 + 3*b] = '{1'b0, 1'b0, 1'b1, 10'b0010010000 | 10'(b)};
         vecs[7 + 3*b] = '{1'b0, 1'b0, 1'b1, 10'b0001010000 | 10'(b)};
      end
      vecs[17] = '{1'b0, 1'b0, 1'b1, 10'b0000011011};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 10'b0000000011};

      for (int i = 0; i < 19; i++) begin
         rst = vecs[i].rst;
         bus.req = vecs[i].req;
         bus.mem_ack = vecs[i].ack;
         step();
         check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      end
      bus.mem_ack = 1'b0;
      check("basic_ldden_count", ldden_tot, 4);
      check("basic_incc2_count", incc2_tot, 4);
      check("basic_word", word_m, 32'h44332211);

      // Three wait cycles before every acknowledge.
      mem_bytes[0] = 8'hA5; mem_bytes[1] = 8'h5A;
      mem_bytes[2] = 8'hC3; mem_bytes[3] = 8'h3C;
      run_xfer(3, done_at, err_at, rd_cycles, ldden_n);
      check("wait3_done_cycle", done_at, 26);
      check("wait3_no_err", err_at, 0);
      check("wait3_mem_rd_cycles", rd_cycles, 16);
      check("wait3_ldden", ldden_n, 4);
      step();
      check("wait3_word", word_m, 32'h3CC35AA5);
      check("wait3_idle_busy", bus.busy, 0);

      // No acknowledge at all: abort after TIMEOUT read cycles.
      run_xfer(-1, done_at, err_at, rd_cycles, ldden_n);
      check("to_err_cycle", err_at, 18);
      check("to_no_done", done_at, 0);
      check("to_mem_rd_cycles", rd_cycles, 16);
      check("to_no_ldden", ldden_n, 0);
      check("to_err_rst2", bus.rst2, 1);
      check("to_err_busy", bus.busy, 1);
      step();
      check("to_idle_busy", bus.busy, 0);
      check("to_idle_err", bus.err, 0);

      // req held high: back-to-back transfers, one IDLE cycle between them.
      ndone = 0; idle_between = 0;
      for (int k = 0; k < 3; k++) d_at[k] = 0;
      bus.req = 1'b1;
      bus.mem_ack = 1'b1;
      step();
      for (int c = 1; c <= 100 && ndone < 3; c++) begin
         if (bus.done) begin
            d_at[ndone] = c;
            ndone++;
            if (ndone == 3) bus.req = 1'b0;
         end
         if (!bus.busy && ndone >= 1 && ndone < 3) idle_between++;
         if (ndone < 3) step();
      end
      bus.mem_ack = 1'b0;
      check("b2b_first_done", d_at[0], 14);
      check("b2b_period_1", d_at[1] - d_at[0], 15);
      check("b2b_period_2", d_at[2] - d_at[1], 15);
      check("b2b_idle_cycles", idle_between, 2);
      step();
      step();
      check("b2b_settle_busy", bus.busy, 0);

      // Reset while reading beat 2, then a normal transfer.
      found = 0;
      bus.req = 1'b1;
      bus.mem_ack = 1'b1;
      step();
      bus.req = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (bus.mem_rd && bus.beat == 2'd2) found = 1;
         else step();
      end
      check("mid_rst_reached_beat2", found, 1);
      done0 = done_tot;
      err0 = err_tot;
      rst = 1'b1;
      bus.mem_ack = 1'b0;
      step();
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_mem_rd", bus.mem_rd, 0);
      check("mid_rst_rst2", bus.rst2, 1);
      rst = 1'b0;
      step();
      check("mid_rst_idle", outs(), 10'b0000000000);
      check("mid_rst_no_done", done_tot - done0, 0);
      check("mid_rst_no_err", err_tot - err0, 0);
      mem_bytes[0] = 8'h01; mem_bytes[1] = 8'h02;
      mem_bytes[2] = 8'h03; mem_bytes[3] = 8'h04;
      run_xfer(0, done_at, err_at, rd_cycles, ldden_n);
      check("post_rst_done_cycle", done_at, 14);
      check("post_rst_no_err", err_at, 0);
      step();
      check("post_rst_word", word_m, 32'h04030201);

      check("ldden_incc2_overlap", overlap_cnt, 0);
      check("beat_vs_datapath_cnt", beat_mis, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
